stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Control FSM and 10 ms tick scheduler for the stopwatch BCD counter chain.
//   Turns debounced one-cycle button pulses into the chain's count enable and
//   synchronous clear. Provides lap freeze: the display holds a captured time
//   while the chain keeps counting. Sits between the button/toggle logic and
//   the cascaded BCD counters; disp_bcd feeds the seven-segment driver.
// PARAMETERS
//   TICK_DIV  1_000_000  clk cycles per count tick (10 ms at 100 MHz); >= 2
//   MAX_STOP  1          1: saturate at 59:59.99; 0: let the chain wrap to 00:00.00
// PORTS
//   clk           in   1   system clock; all logic on rising edge
//   reset_n       in   1   asynchronous, active-low reset
//   start_stop_p  in   1   one-cycle debounced pulse: start/pause/resume
//   lap_reset_p   in   1   one-cycle debounced pulse: lap capture/release, or reset
//   time_bcd      in   24  live chain value {mT,mO,sT,sO,cT,cO}, 4-bit BCD each
//   tick_en       out  1   one-cycle count enable to least-significant BCD counter
//   clr           out  1   one-cycle synchronous clear to all BCD counters
//   disp_bcd      out  24  value to display: lap_reg in LAP, else time_bcd
//   running       out  1   1 in RUN or LAP
//   lap_active    out  1   1 in LAP
//   at_max        out  1   sticky: saturation stop occurred (MAX_STOP=1 only)
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, prescaler=0, lap_reg=0, tick_en=0,
//     clr=0, at_max=0. Outputs: running=0, lap_active=0, disp_bcd=time_bcd.
//   States: IDLE, RUN, LAP, PAUSE. The state register and all outputs except
//     disp_bcd are registered. disp_bcd is a combinational mux.
//   Transitions (pulse sampled at edge n; new state and clr visible after edge n):
//     IDLE : start_stop -> RUN; lap_reset -> IDLE, clr=1 for one cycle
//     RUN  : start_stop -> PAUSE; lap_reset -> LAP, lap_reg<=time_bcd same edge
//     LAP  : start_stop -> PAUSE (display goes live); lap_reset -> RUN (live)
//     PAUSE: start_stop -> RUN; lap_reset -> IDLE, clr=1 for one cycle
//   Both pulses on the same edge: start_stop wins; lap_reset is ignored.
//   Prescaler:
//     - Counts 0..TICK_DIV-1 in RUN and LAP. tick_en=1 for the single cycle
//       after the edge where prescaler==TICK_DIV-1; prescaler wraps to 0.
//     - Holds its value in PAUSE, so a resumed partial interval is preserved.
//     - Forced to 0 in IDLE and on any clr.
//   Tick period in steady RUN: exactly TICK_DIV cycles. LAP does not perturb it.
//   Saturation (MAX_STOP=1):
//     - If time_bcd==24'h595999 at the prescaler terminal count, suppress
//       tick_en, go to PAUSE, and set at_max.
//     - While at_max=1, start_stop in PAUSE is ignored; only lap_reset (-> IDLE)
//       is accepted. at_max clears when the FSM enters IDLE.
//   MAX_STOP=0: no suppression; the chain wraps and the FSM stays in RUN.
//   clr and tick_en are never asserted in the same cycle.
//   lap_reg is written only on RUN->LAP. It keeps its value otherwise and is
//     not shown outside LAP.
//   Reset mid-operation: immediate return to reset values. Any pending tick is
//     discarded.
// TESTING (TICK_DIV=4 unless noted)
//   T1: reset, start_stop -> running=1 next cycle; tick_en every 4th cycle;
//     after 10 ticks the chain reads 00:00.10.
//   T2: RUN 2 cycles past a tick, start_stop, idle 20 cycles, start_stop ->
//     no tick while paused; first tick 2 cycles after resume.
//   T3: time_bcd=24'h000123, lap_reset -> lap_active=1, disp_bcd=000123 while
//     time_bcd advances and ticks continue; lap_reset -> disp_bcd=time_bcd.
//   T4: PAUSE, lap_reset -> clr=1 for exactly one cycle, state IDLE, no tick;
//     both pulses on the same edge in RUN -> PAUSE, lap_active stays 0.
//   T5: time_bcd held at 24'h595999 in RUN -> no tick_en, PAUSE, at_max=1;
//     start_stop ignored; lap_reset -> IDLE, at_max=0. With MAX_STOP=0 ->
//     tick_en fires and FSM stays RUN.
//   T6: assert reset_n=0 asynchronously mid-interval in LAP -> all outputs at
//     reset values before the next edge; after release, a start gives its
//     first tick 4 cycles later.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button-side and chain-side signals of the stopwatch controller.
// The controller uses the slave modport; the button logic and BCD chain side uses master.
interface stopwatch_ctrl_if;
  logic        start_stop_p;
  logic        lap_reset_p;
  logic [23:0] time_bcd;
  logic        tick_en;
  logic        clr;
  logic [23:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        at_max;

  modport master (
    output start_stop_p, lap_reset_p, time_bcd,
    input  tick_en, clr, disp_bcd, running, lap_active, at_max
  );

  modport slave (
    input  start_stop_p, lap_reset_p, time_bcd,
    output tick_en, clr, disp_bcd, running, lap_active, at_max
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with a 10 ms tick prescaler and lap freeze.
// Drives the BCD chain's count enable and clear; muxes the lap capture onto the display.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1_000_000,
  parameter bit MAX_STOP = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  stopwatch_ctrl_if.slave sw
);
  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TERM    = PW'(TICK_DIV - 1);
  localparam logic [23:0]     MAX_BCD = 24'h595999;

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  state_t        state, stateNxt;
  logic [PW-1:0] presc, prescNxt;
  logic [23:0]   lapReg;
  logic          tickEn, tickNxt;
  logic          clrQ, clrNxt;
  logic          atMax, atMaxNxt;
  logic          runQ, lapQ;
  logic          lapCap;
  logic          counting, termCnt;

  assign counting = (state == RUN) || (state == LAP);
  assign termCnt  = (presc == TERM);

  always_comb begin
    stateNxt = state;
    prescNxt = presc;
    tickNxt  = 1'b0;
    clrNxt   = 1'b0;
    atMaxNxt = atMax;
    lapCap   = 1'b0;

    // A start/stop pulse landing on the terminal edge still delivers that tick.
    if (counting) prescNxt = termCnt ? '0 : presc + 1'b1;

    case (state)
      IDLE: begin
        prescNxt = '0;
        if (sw.start_stop_p)       stateNxt = RUN;
        else if (sw.lap_reset_p)   clrNxt   = 1'b1;
      end
      RUN: begin
        if (sw.start_stop_p)       stateNxt = PAUSE;
        else if (sw.lap_reset_p) begin
          stateNxt = LAP;
          lapCap   = 1'b1;
        end
      end
      LAP: begin
        if (sw.start_stop_p)       stateNxt = PAUSE;
        else if (sw.lap_reset_p)   stateNxt = RUN;
      end
      PAUSE: begin
        // After saturation only a reset gets the stopwatch going again.
        if (sw.start_stop_p && !atMax) stateNxt = RUN;
        else if (sw.lap_reset_p) begin
          stateNxt = IDLE;
          clrNxt   = 1'b1;
          atMaxNxt = 1'b0;
          prescNxt = '0;
        end
      end
      default: stateNxt = IDLE;
    endcase

    if (counting && termCnt) begin
      if (MAX_STOP && (sw.time_bcd == MAX_BCD)) begin
        stateNxt = PAUSE;
        atMaxNxt = 1'b1;
        lapCap   = 1'b0;
      end else begin
        tickNxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      presc  <= '0;
      lapReg <= '0;
      tickEn <= 1'b0;
      clrQ   <= 1'b0;
      atMax  <= 1'b0;
      runQ   <= 1'b0;
      lapQ   <= 1'b0;
    end else begin
      state  <= stateNxt;
      presc  <= prescNxt;
      if (lapCap) lapReg <= sw.time_bcd;
      tickEn <= tickNxt;
      clrQ   <= clrNxt;
      atMax  <= atMaxNxt;
      runQ   <= (stateNxt == RUN) || (stateNxt == LAP);
      lapQ   <= (stateNxt == LAP);
    end
  end

  assign sw.tick_en    = tickEn;
  assign sw.clr        = clrQ;
  assign sw.running    = runQ;
  assign sw.lap_active = lapQ;
  assign sw.at_max     = atMax;
  assign sw.disp_bcd   = lapQ ? lapReg : sw.time_bcd;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl: two instances (saturating and wrapping) share the
// button pulses; each is fed by its own centisecond chain model and checked against a reference.
module tb_stopwatch_ctrl;
  localparam int TDIV  = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_PAUSE = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_if if0 ();
  stopwatch_ctrl_if if1 ();

  stopwatch_ctrl #(.TICK_DIV(TDIV), .MAX_STOP(1'b1)) dut0 (.clk(clk), .reset_n(reset_n), .sw(if0));
  stopwatch_ctrl #(.TICK_DIV(TDIV), .MAX_STOP(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .sw(if1));

  int nVec = 0;
  int nErr = 0;

  // Reference state per instance: 0 saturating, 1 wrapping.
  int          mSt[2];
  int          mPh[2];
  logic [23:0] mLap[2];
  bit          mAtMax[2];
  bit          mTick[2];
  bit          mClr[2];
  int          chain[2];
  logic [23:0] tIn[2];

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s @%0t got %h exp %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [23:0] toBcd(input int c);
    int cs, s, m;
    cs = c % 100;
    s  = (c / 100) % 60;
    m  = (c / 6000) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mSt[d] = S_IDLE; mPh[d] = 0; mLap[d] = '0;
      mAtMax[d] = 1'b0; mTick[d] = 1'b0; mClr[d] = 1'b0;
    end
  endtask

  // Centisecond chain reacts to the enable/clear it saw during the previous cycle.
  task automatic chainEdge(input int d);
    if (mClr[d])       chain[d] = 0;
    else if (mTick[d]) chain[d] = (chain[d] + 1) % 360000;
  endtask

  task automatic modelEdge(input int d, input bit ss, input bit lr, input bit maxStop);
    bit sat;
    int ns;
    sat = 1'b0;
    ns  = mSt[d];
    mTick[d] = 1'b0;
    mClr[d]  = 1'b0;
    if (mSt[d] == S_RUN || mSt[d] == S_LAP) begin
      mPh[d]++;
      if (mPh[d] == TDIV) begin
        mPh[d] = 0;
        if (maxStop && tIn[d] == 24'h595999) sat = 1'b1;
        else mTick[d] = 1'b1;
      end
    end
    if (sat) begin
      ns = S_PAUSE;
      mAtMax[d] = 1'b1;
    end else begin
      case (mSt[d])
        S_IDLE: begin
          mPh[d] = 0;
          if (ss) ns = S_RUN;
          else if (lr) mClr[d] = 1'b1;
        end
        S_RUN: begin
          if (ss) ns = S_PAUSE;
          else if (lr) begin ns = S_LAP; mLap[d] = tIn[d]; end
        end
        S_LAP: begin
          if (ss) ns = S_PAUSE;
          else if (lr) ns = S_RUN;
        end
        default: begin
          if (ss && !mAtMax[d]) ns = S_RUN;
          else if (lr) begin
            ns = S_IDLE; mClr[d] = 1'b1; mAtMax[d] = 1'b0; mPh[d] = 0;
          end
        end
      endcase
    end
    mSt[d] = ns;
  endtask

  task automatic checkAll();
    logic run0, run1;
    run0 = (mSt[0] == S_RUN) || (mSt[0] == S_LAP);
    run1 = (mSt[1] == S_RUN) || (mSt[1] == S_LAP);
    chk("d0.tick_en",    24'(if0.tick_en),    24'(mTick[0]));
    chk("d0.clr",        24'(if0.clr),        24'(mClr[0]));
    chk("d0.running",    24'(if0.running),    24'(run0));
    chk("d0.lap_active", 24'(if0.lap_active), 24'(mSt[0] == S_LAP));
    chk("d0.at_max",     24'(if0.at_max),     24'(mAtMax[0]));
    chk("d0.disp_bcd",   if0.disp_bcd,        (mSt[0] == S_LAP) ? mLap[0] : tIn[0]);
    chk("d1.tick_en",    24'(if1.tick_en),    24'(mTick[1]));
    chk("d1.clr",        24'(if1.clr),        24'(mClr[1]));
    chk("d1.running",    24'(if1.running),    24'(run1));
    chk("d1.lap_active", 24'(if1.lap_active), 24'(mSt[1] == S_LAP));
    chk("d1.at_max",     24'(if1.at_max),     24'(mAtMax[1]));
    chk("d1.disp_bcd",   if1.disp_bcd,        (mSt[1] == S_LAP) ? mLap[1] : tIn[1]);
  endtask

  // One clock: drive at the falling edge, check 1 ns later, optionally pulse reset
  // asynchronously mid-cycle, then advance the reference on the rising edge.
  task automatic cyc(input bit ss, input bit lr, input bit jmp, input bit rst);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (jmp) chain[d] = 359996;
      tIn[d] = toBcd(chain[d]);
    end
    if0.time_bcd = tIn[0];     if1.time_bcd = tIn[1];
    if0.start_stop_p = ss;     if1.start_stop_p = ss;
    if0.lap_reset_p  = lr;     if1.lap_reset_p  = lr;
    #1 checkAll();
    if (rst) begin
      #1 reset_n = 1'b0;
      modelReset();
      #1 checkAll();
      #1 reset_n = 1'b1;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      chainEdge(d);
      modelEdge(d, ss, lr, (d == 0));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    modelReset();
    for (int d = 0; d < 2; d++) begin chain[d] = 0; tIn[d] = '0; end
    if0.start_stop_p = 1'b0; if0.lap_reset_p = 1'b0; if0.time_bcd = '0;
    if1.start_stop_p = 1'b0; if1.lap_reset_p = 1'b0; if1.time_bcd = '0;
    #3 checkAll();
    #14 reset_n = 1'b1;

    // start, then ten and more ticks
    cyc(1, 0, 0, 0); idle(45);
    // pause two cycles past a tick, wait, resume
    idle(1); cyc(1, 0, 0, 0); idle(20); cyc(1, 0, 0, 0); idle(10);
    // lap capture while counting, then release
    cyc(0, 1, 0, 0); idle(13); cyc(0, 1, 0, 0); idle(6);
    // pause, reset to idle; then both pulses together in RUN
    cyc(1, 0, 0, 0); idle(3); cyc(0, 1, 0, 0); idle(3);
    cyc(1, 0, 0, 0); idle(5); cyc(1, 1, 0, 0); idle(4);
    // saturation on one instance, wrap on the other
    cyc(0, 1, 0, 0); idle(2); cyc(0, 0, 1, 0); cyc(1, 0, 0, 0); idle(20);
    cyc(1, 0, 0, 0); idle(4); cyc(0, 1, 0, 0); idle(4);
    // reset mid-interval in LAP, then restart
    cyc(1, 0, 0, 0); idle(6); cyc(0, 1, 0, 0); idle(2); cyc(0, 0, 0, 1);
    idle(2); cyc(1, 0, 0, 0); idle(8);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 149) == 0), ($urandom_range(0, 399) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
